// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Purpose  : Shared types, widths and the fetch state encoding used by the
//            instruction-fetch stage, its cache and its bus interface.
// Contents : inst_addr_t / inst_t / mem_byte_t, ZERO_WORD,
//            if_state_e (S0..S4, DONE), state_offset() helper.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int MEM_BYTE_W  = 8;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [MEM_BYTE_W-1:0]  mem_byte_t;

  localparam inst_addr_t ZERO_WORD = '0;

  // S0..S3 issue byte pc+0..pc+3; S1..S4 capture the byte requested in the
  // previous cycle; DONE holds the assembled instruction for if_id.
  typedef enum logic [2:0] {
    IF_S0   = 3'd0,
    IF_S1   = 3'd1,
    IF_S2   = 3'd2,
    IF_S3   = 3'd3,
    IF_S4   = 3'd4,
    IF_DONE = 3'd5
  } if_state_e;

  // Byte offset from pc addressed in a given state.
  function automatic inst_addr_t state_offset(input if_state_e s);
    inst_addr_t off;
    off = ZERO_WORD;
    case (s)
      IF_S1:   off = 32'd1;
      IF_S2:   off = 32'd2;
      IF_S3:   off = 32'd3;
      IF_S4:   off = 32'd4;
      default: off = ZERO_WORD;
    endcase
    return off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_if
// Purpose  : Bundles the fetch stage's memory byte port, redirect inputs,
//            if_id back-pressure and the delivered {flag, pc, inst}.
// Modports : master - the fetch stage (drives mem_rd_o/mem_addr_o/flag_o/
//                     pc_o/inst_o)
//            slave  - the surroundings (memory, decoder, if_id register)
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic       stall_i;
  logic       branch_i;
  inst_addr_t jump_addr_i;
  logic       mem_busy_i;
  mem_byte_t  mem_din_i;
  logic       mem_rd_o;
  inst_addr_t mem_addr_o;
  logic       flag_o;
  inst_addr_t pc_o;
  inst_t      inst_o;

  modport master (
    input  stall_i, branch_i, jump_addr_i, mem_busy_i, mem_din_i,
    output mem_rd_o, mem_addr_o, flag_o, pc_o, inst_o
  );

  modport slave (
    output stall_i, branch_i, jump_addr_i, mem_busy_i, mem_din_i,
    input  mem_rd_o, mem_addr_o, flag_o, pc_o, inst_o
  );

endinterface
`default_nettype wire

// File: rtl/if_fetch_icache.sv
`default_nettype none
// ============================================================================
// Module   : if_icache
// Purpose  : Direct-mapped instruction cache for the fetch stage. One word
//            per line; combinational lookup, single-cycle fill.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            addr_i[31:2]    - word address used for lookup and fill
//            hit_o, data_o   - lookup result
//            fill_i, fill_data_i - write the line addressed by addr_i
// Config   : compiled only when ICACHE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef ICACHE_EN
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] addr_i,
  output logic        hit_o,
  output inst_t       data_o,
  input  logic        fill_i,
  input  inst_t       fill_data_i
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_mem [LINES];
  inst_t            data_mem [LINES];

  assign idx = addr_i[IDX_W+1:2];
  assign tag = addr_i[31:IDX_W+2];

  assign hit_o  = valid_q[idx] && (tag_mem[idx] == tag);
  assign data_o = data_mem[idx];

  always_comb begin
    valid_d = valid_q;
    if (fill_i) begin
      valid_d[idx] = 1'b1;
    end
  end

  // Only the valid bits are reset; tag/data are don't-care until filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_i) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= fill_data_i;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage. Owns the PC, reads four bytes
//            little-endian from the byte-wide memory port and delivers
//            {flag, pc, inst} to if_id. A decoder redirect restarts fetch at
//            the jump target.
// Ports    : clk   - clock
//            rst   - synchronous reset, active-high
//            bus   - if_fetch_if.master: stall_i, branch_i, jump_addr_i,
//                    mem_busy_i, mem_din_i in; mem_rd_o, mem_addr_o
//                    (combinational), flag_o, pc_o, inst_o (registered) out
// Params   : ICACHE_IDX_W - log2 of I-cache lines (only with ICACHE_EN)
// Config   : ICACHE_EN - adds a direct-mapped I-cache (if_icache); a hit in
//            S0 delivers the instruction without touching memory.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_IDX_W = 7
) (
  input  logic     clk,
  input  logic     rst,
  if_fetch_if.master bus
);

  if_state_e  state_q, state_d;
  inst_addr_t pc_q, pc_d;
  logic       flag_q, flag_d;
  inst_addr_t pc_out_q, pc_out_d;
  inst_t      inst_q, inst_d;
  logic [23:0] buf_q, buf_d;   // b2,b1,b0 gathered so far

  logic       cache_hit;
  inst_t      cache_data;
  logic       issue_state;
  logic       mem_rd;
  inst_addr_t mem_addr;

`ifdef ICACHE_EN
  logic fill_en;

  // A fill happens only when S4 actually completes the miss.
  assign fill_en = (state_q == IF_S4) && !bus.branch_i && !bus.mem_busy_i;

  if_icache #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (pc_q[31:2]),
    .hit_o       (cache_hit),
    .data_o      (cache_data),
    .fill_i      (fill_en),
    .fill_data_i ({bus.mem_din_i, buf_q})
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = ZERO_WORD;
`endif

  assign issue_state = (state_q == IF_S0) || (state_q == IF_S1) ||
                       (state_q == IF_S2) || (state_q == IF_S3);

  // Memory request is combinational so the byte returns the next cycle.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = ZERO_WORD;
    if (!rst) begin
      mem_addr = pc_q + state_offset(state_q);
      mem_rd   = issue_state && !bus.mem_busy_i && !bus.branch_i &&
                 !((state_q == IF_S0) && cache_hit);
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flag_d   = flag_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    buf_d    = buf_q;

    if (bus.branch_i) begin
      pc_d    = bus.jump_addr_i;
      state_d = IF_S0;
      flag_d  = 1'b0;
    end else if (bus.mem_busy_i && (state_q != IF_DONE)) begin
      // Port lost to MEM: drop partial bytes and reissue from pc+0.
      state_d = IF_S0;
    end else begin
      case (state_q)
        IF_S0: begin
          if (cache_hit) begin
            state_d  = IF_DONE;
            flag_d   = 1'b1;
            pc_out_d = pc_q;
            inst_d   = cache_data;
          end else begin
            state_d = IF_S1;
          end
        end
        IF_S1: begin
          buf_d[7:0] = bus.mem_din_i;
          state_d    = IF_S2;
        end
        IF_S2: begin
          buf_d[15:8] = bus.mem_din_i;
          state_d     = IF_S3;
        end
        IF_S3: begin
          buf_d[23:16] = bus.mem_din_i;
          state_d      = IF_S4;
        end
        IF_S4: begin
          flag_d   = 1'b1;
          pc_out_d = pc_q;
          inst_d   = {bus.mem_din_i, buf_q};
          state_d  = IF_DONE;
        end
        IF_DONE: begin
          if (!bus.stall_i) begin
            pc_d    = pc_q + 32'd4;
            flag_d  = 1'b0;
            state_d = IF_S0;
          end
        end
        default: begin
          state_d = IF_S0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IF_S0;
      pc_q     <= ZERO_WORD;
      flag_q   <= 1'b0;
      pc_out_q <= ZERO_WORD;
      inst_q   <= ZERO_WORD;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flag_q   <= flag_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      buf_q    <= buf_d;
    end
  end

  assign bus.mem_rd_o   = mem_rd;
  assign bus.mem_addr_o = mem_addr;
  assign bus.flag_o     = flag_q;
  assign bus.pc_o       = pc_out_q;
  assign bus.inst_o     = inst_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch. A memory responder returns
//            bytes for granted requests; a transaction-level model predicts
//            requests and deliveries cycle by cycle. Directed scenarios are
//            followed by randomized redirects, memory contention and stalls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam int IDX_W = 7;

  logic clk;
  logic rst;

  if_fetch_if bus ();

  if_fetch #(
    .ICACHE_IDX_W (IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Memory responder state (what the DUT asked for last cycle).
  logic        prev_req;
  logic [31:0] prev_addr;

  // Observed DUT outputs of the latest step.
  logic        obs_rd;
  logic [31:0] obs_addr;
  logic        obs_flag;
  logic [31:0] obs_pc;
  logic [31:0] obs_inst;

  // Transaction-level model: pc of the instruction being fetched, number of
  // its bytes already requested, whether a finished instruction is held.
  logic [31:0] m_pc;
  int          m_k;
  bit          m_hold;
  bit          m_known;
  logic        m_flag;
  logic [31:0] m_pc_o;
  logic [31:0] m_inst_o;
  logic [31:0] c_pc [int];
  logic [31:0] c_dat [int];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] lo;
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h00;
      32'd3:   return 8'h00;
      default: begin
        lo = a[7:0] * 8'd37;
        return lo ^ a[15:8] ^ a[23:16] ^ 8'h5a;
      end
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2),
            mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic int c_idx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << IDX_W) - 32'd1));
  endfunction

  function automatic bit c_lookup(input logic [31:0] a);
`ifdef ICACHE_EN
    int i;
    i = c_idx(a);
    return c_pc.exists(i) && ((c_pc[i] >> (IDX_W + 2)) == (a >> (IDX_W + 2)));
`else
    return a === 32'hxxxxxxxx;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check all outputs against the model,
  // then advance the model by the spec's rules.
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] ja, input logic bz);
    bit          hit;
    logic        exp_rd;
    logic [31:0] exp_addr;
    @(negedge clk);
    rst             = r;
    bus.stall_i     = s;
    bus.branch_i    = b;
    bus.jump_addr_i = ja;
    bus.mem_busy_i  = bz;
    bus.mem_din_i   = prev_req ? mem_byte(prev_addr) : 8'($urandom);
    #1;
    obs_rd   = bus.mem_rd_o;
    obs_addr = bus.mem_addr_o;
    obs_flag = bus.flag_o;
    obs_pc   = bus.pc_o;
    obs_inst = bus.inst_o;

    hit      = m_known && !m_hold && (m_k == 0) && c_lookup(m_pc);
    exp_rd   = !r && !b && !bz && m_known && !m_hold && (m_k < 4) && !hit;
    exp_addr = r ? 32'd0 : m_pc + 32'(m_k);
    chk("mem_rd_o", {31'd0, obs_rd}, {31'd0, exp_rd});
    if (exp_rd || r) chk("mem_addr_o", obs_addr, exp_addr);
    if (m_known) begin
      chk("flag_o", {31'd0, obs_flag}, {31'd0, m_flag});
      chk("pc_o", obs_pc, m_pc_o);
      chk("inst_o", obs_inst, m_inst_o);
    end
    prev_req  = obs_rd;
    prev_addr = obs_addr;

    if (r) begin
      m_pc = 0; m_k = 0; m_hold = 0; m_known = 1;
      m_flag = 0; m_pc_o = 0; m_inst_o = 0;
      c_pc.delete(); c_dat.delete();
    end else if (!m_known) begin
      // nothing predictable before the first reset
    end else if (b) begin
      m_pc = ja; m_k = 0; m_hold = 0; m_flag = 0;
    end else if (m_hold) begin
      if (!s) begin
        m_pc = m_pc + 32'd4; m_hold = 0; m_flag = 0; m_k = 0;
      end
    end else if (bz) begin
      m_k = 0;
    end else if (hit) begin
      m_hold = 1; m_flag = 1; m_pc_o = m_pc; m_inst_o = c_dat[c_idx(m_pc)];
    end else if (m_k < 4) begin
      m_k++;
    end else begin
      m_hold = 1; m_flag = 1; m_k = 0;
      m_pc_o = m_pc; m_inst_o = mem_word(m_pc);
`ifdef ICACHE_EN
      c_pc[c_idx(m_pc)]  = m_pc;
      c_dat[c_idx(m_pc)] = m_inst_o;
`endif
    end
  endtask

  task automatic idle(input logic s);
    step(1'b0, s, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    prev_req = 0; prev_addr = 0;
    m_pc = 0; m_k = 0; m_hold = 0; m_known = 0;
    m_flag = 0; m_pc_o = 0; m_inst_o = 0;
    rst = 1'b1;
    bus.stall_i = 0; bus.branch_i = 0; bus.jump_addr_i = 0;
    bus.mem_busy_i = 0; bus.mem_din_i = 0;

    // Reset
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("reset_flag", {31'd0, obs_flag}, 32'd0);
    chk("reset_pc", obs_pc, 32'd0);
    chk("reset_inst", obs_inst, 32'd0);
    chk("reset_addr", obs_addr, 32'd0);

    // 1: four consecutive byte requests, delivery five cycles after the first
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("t1_rd", {31'd0, obs_rd}, 32'd1);
      chk("t1_addr", obs_addr, 32'(i));
    end
    idle(1'b1);
    chk("t1_flag_early", {31'd0, obs_flag}, 32'd0);
    idle(1'b1);
    chk("t1_flag", {31'd0, obs_flag}, 32'd1);
    chk("t1_pc", obs_pc, 32'd0);
    chk("t1_inst", obs_inst, 32'h0000_0513);

    // 2: stall holds the instruction with no memory traffic
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("t2_hold_flag", {31'd0, obs_flag}, 32'd1);
      chk("t2_hold_inst", obs_inst, 32'h0000_0513);
      chk("t2_hold_rd", {31'd0, obs_rd}, 32'd0);
    end
    idle(1'b0);
    idle(1'b0);
    chk("t2_next_rd", {31'd0, obs_rd}, 32'd1);
    chk("t2_next_addr", obs_addr, 32'h4);
    chk("t2_next_flag", {31'd0, obs_flag}, 32'd0);

    // 3: memory contention during S2 restarts the fetch
    idle(1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("t3_busy_rd", {31'd0, obs_rd}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(1'b0);
    chk("t3_restart_addr", obs_addr, 32'h4);
    for (int i = 0; i < 4; i++) idle(1'b0);
    idle(1'b1);
    chk("t3_pc", obs_pc, 32'h4);
    chk("t3_inst", obs_inst, 32'h5984_E3CE);
    idle(1'b0);

    // 4: redirect while in S3
    idle(1'b0);
    chk("t4_addr8", obs_addr, 32'h8);
    idle(1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    chk("t4_branch_rd", {31'd0, obs_rd}, 32'd0);
    idle(1'b0);
    chk("t4_target_addr", obs_addr, 32'h100);
    chk("t4_flag", {31'd0, obs_flag}, 32'd0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    idle(1'b1);
    chk("t4_pc", obs_pc, 32'h100);

    // 5: redirect while holding a stalled instruction
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    chk("t5_flag_before", {31'd0, obs_flag}, 32'd1);
    idle(1'b1);
    chk("t5_flag_drop", {31'd0, obs_flag}, 32'd0);
    chk("t5_addr", obs_addr, 32'h200);

    // PC wrap-around at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    idle(1'b1);
    chk("wrap_pc", obs_pc, 32'hFFFF_FFFC);
    idle(1'b0);
    idle(1'b0);
    chk("wrap_addr", obs_addr, 32'h0);

`ifdef ICACHE_EN
    // 6: second fetch of 0x0 hits the cache; reset flushes it
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    idle(1'b1);
    chk("t6_fill_flag", {31'd0, obs_flag}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    idle(1'b1);
    chk("t6_hit_rd", {31'd0, obs_rd}, 32'd0);
    idle(1'b1);
    chk("t6_hit_flag", {31'd0, obs_flag}, 32'd1);
    chk("t6_hit_inst", obs_inst, 32'h0000_0513);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(1'b1);
    chk("t6_miss_rd", {31'd0, obs_rd}, 32'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);
    chk("t6_miss_flag", {31'd0, obs_flag}, 32'd1);
`endif

    // Randomized redirects, contention, stalls and occasional resets
    for (int n = 0; n < 4000; n++) begin
      logic        r, s, b, bz;
      logic [31:0] ja;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 15) == 0);
      bz = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0:       ja = 32'h0;
        1:       ja = 32'h100;
        2:       ja = 32'hFFFF_FFF8;
        3:       ja = 32'h200 + 32'($urandom_range(0, 15)) * 4;
        4:       ja = 32'($urandom_range(0, 63)) * 4;
        default: ja = $urandom;
      endcase
      step(r, s, b, ja, bz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
